// File: rtl/square_root_mantissa_seq.sv
// Iterative radix-2 restoring square root of a BINARY_SIZE-bit radicand, one root bit per clock.
// Optional round-to-nearest of the root (with exponent carry report) is enabled by macro SQRT_ROUND_EN.
module square_root_mantissa_seq #(
  parameter int MANTISSA_SIZE    = 52,
  parameter int HALF_BINARY_SIZE = MANTISSA_SIZE + 1,
  parameter int BINARY_SIZE      = 2 * HALF_BINARY_SIZE
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [BINARY_SIZE-1:0]   op_a,
  output logic                     busy,
  output logic                     done,
  output logic [MANTISSA_SIZE-1:0] mantissa,
  output logic                     root_msb,
  output logic                     inexact,
  output logic                     exp_inc
);

  localparam int H = HALF_BINARY_SIZE;
`ifdef SQRT_ROUND_EN
  localparam int N_ITER = H + 1;
`else
  localparam int N_ITER = H;
`endif
  // Root holds one extra guard bit when rounding; remainder is sized so the compare never truncates.
  localparam int QW = N_ITER;
  localparam int RW = QW + 2;
  localparam int CW = $clog2(N_ITER + 1);

  generate
    if (BINARY_SIZE != 2 * HALF_BINARY_SIZE) begin : g_bad_width
      $error("square_root_mantissa_seq: BINARY_SIZE must equal 2*HALF_BINARY_SIZE");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [BINARY_SIZE-1:0]   op_q, op_d;
  logic [QW-1:0]            q_q, q_d;
  logic [RW-1:0]            r_q, r_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic                     busy_q, busy_d;
  logic                     done_q, done_d;
  logic [MANTISSA_SIZE-1:0] mant_q, mant_d;
  logic                     msb_q, msb_d;
  logic                     inexact_q, inexact_d;
  logic                     exp_inc_q, exp_inc_d;

  logic [RW-1:0]            r_shift_s, t_s, r_iter_s;
  logic [QW-1:0]            q_iter_s;
  logic [MANTISSA_SIZE-1:0] mant_fin_s;
  logic                     msb_fin_s, inexact_fin_s, exp_inc_fin_s;
`ifdef SQRT_ROUND_EN
  logic [H:0]               root_rnd_s;
  logic                     guard_s;
`endif

  // One restoring iteration on the current root/remainder.
  always_comb begin
    r_shift_s = {r_q[RW-3:0], op_q[BINARY_SIZE-1 -: 2]};
    t_s       = {q_q, 2'b01};
    if (r_shift_s >= t_s) begin
      r_iter_s = r_shift_s - t_s;
      q_iter_s = {q_q[QW-2:0], 1'b1};
    end else begin
      r_iter_s = r_shift_s;
      q_iter_s = {q_q[QW-2:0], 1'b0};
    end
  end

  // Result formatting from the last iteration's root and remainder.
  always_comb begin
`ifdef SQRT_ROUND_EN
    guard_s       = q_iter_s[0];
    root_rnd_s    = {1'b0, q_iter_s[QW-1:1]} + {{H{1'b0}}, guard_s};
    inexact_fin_s = guard_s | (r_iter_s != {RW{1'b0}});
    exp_inc_fin_s = root_rnd_s[H];
    if (root_rnd_s[H]) begin
      mant_fin_s = {MANTISSA_SIZE{1'b0}};
      msb_fin_s  = 1'b1;
    end else begin
      mant_fin_s = root_rnd_s[MANTISSA_SIZE-1:0];
      msb_fin_s  = root_rnd_s[H-1];
    end
`else
    mant_fin_s    = q_iter_s[MANTISSA_SIZE-1:0];
    msb_fin_s     = q_iter_s[H-1];
    inexact_fin_s = (r_iter_s != {RW{1'b0}});
    exp_inc_fin_s = 1'b0;
`endif
  end

  // Next-state and datapath control.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    q_d       = q_q;
    r_d       = r_q;
    cnt_d     = cnt_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    mant_d    = mant_q;
    msb_d     = msb_q;
    inexact_d = inexact_q;
    exp_inc_d = exp_inc_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          state_d = S_CALC;
          op_d    = op_a;
          q_d     = {QW{1'b0}};
          r_d     = {RW{1'b0}};
          cnt_d   = CW'(N_ITER);
          busy_d  = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CALC: begin
        op_d  = {op_q[BINARY_SIZE-3:0], 2'b00};
        q_d   = q_iter_s;
        r_d   = r_iter_s;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          mant_d    = mant_fin_s;
          msb_d     = msb_fin_s;
          inexact_d = inexact_fin_s;
          exp_inc_d = exp_inc_fin_s;
        end else begin
          state_d = S_CALC;
        end
      end
      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= {BINARY_SIZE{1'b0}};
      q_q       <= {QW{1'b0}};
      r_q       <= {RW{1'b0}};
      cnt_q     <= {CW{1'b0}};
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      mant_q    <= {MANTISSA_SIZE{1'b0}};
      msb_q     <= 1'b0;
      inexact_q <= 1'b0;
      exp_inc_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      q_q       <= q_d;
      r_q       <= r_d;
      cnt_q     <= cnt_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      mant_q    <= mant_d;
      msb_q     <= msb_d;
      inexact_q <= inexact_d;
      exp_inc_q <= exp_inc_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign mantissa = mant_q;
  assign root_msb = msb_q;
  assign inexact  = inexact_q;
  assign exp_inc  = exp_inc_q;

endmodule
